// File: rtl/regfile_pkg.sv
// Shared constants for the operand-read stage: register/operand width,
// architectural register count, index width and the hardwired-zero index.
package regfile_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int NUM_REGS   = 32;
  localparam int ADDR_WIDTH = 5;

  typedef logic [ADDR_WIDTH-1:0] reg_idx_t;
  typedef logic [DATA_WIDTH-1:0] reg_data_t;

  localparam reg_idx_t REG_ZERO = '0;

endpackage

// File: rtl/register_read_unit_if.sv
// Issue / writeback / execute-facing bundle of the operand-read stage.
// master = pipeline side driving issue and writeback, slave = register_read_unit.
interface register_read_unit_if;
  import regfile_pkg::*;

  logic      issue_valid;
  logic      issue_ready;
  reg_idx_t  issue_rs;
  reg_idx_t  issue_rt;
  reg_idx_t  issue_rd;
  logic      issue_wen;

  logic      wb_valid;
  reg_idx_t  wb_rd;
  reg_data_t wb_data;

  logic      out_valid;
  logic      out_ready;
  reg_data_t rs_data;
  reg_data_t rt_data;
  reg_idx_t  out_rd;
  logic      out_wen;

  modport master (
    output issue_valid, issue_rs, issue_rt, issue_rd, issue_wen,
    output wb_valid, wb_rd, wb_data, out_ready,
    input  issue_ready, out_valid, rs_data, rt_data, out_rd, out_wen
  );

  modport slave (
    input  issue_valid, issue_rs, issue_rt, issue_rd, issue_wen,
    input  wb_valid, wb_rd, wb_data, out_ready,
    output issue_ready, out_valid, rs_data, rt_data, out_rd, out_wen
  );

endinterface

// File: rtl/register_read_unit_reg_scoreboard.sv
// Pending-write scoreboard: one busy bit per architectural register.
// Set on an accepted writing issue, cleared by writeback; set wins on a tie.
// With REGFILE_BYPASS_EN a same-cycle matching writeback unblocks the index.
module reg_scoreboard
  import regfile_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     set_en,
  input  reg_idx_t set_idx,
  input  logic     clr_en,
  input  reg_idx_t clr_idx,
  input  reg_idx_t rs_idx,
  input  reg_idx_t rt_idx,
  input  reg_idx_t rd_idx,
  output logic     rs_blocked,
  output logic     rt_blocked,
  output logic     rd_blocked
);

  logic [NUM_REGS-1:0] busy;

  // busy[0] is never set, so r0 can never be a hazard
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (set_en && set_idx == ADDR_WIDTH'(i))
          busy[i] <= 1'b1;
        else if (clr_en && clr_idx == ADDR_WIDTH'(i))
          busy[i] <= 1'b0;
      end
    end
  end

  function automatic logic blocked(input reg_idx_t x);
    logic b;
    b = (x != REG_ZERO) && busy[x];
`ifdef REGFILE_BYPASS_EN
    b = b && !(clr_en && clr_idx == x);
`endif
    return b;
  endfunction

  // hazard flags for the three indices of the offered instruction
  always_comb begin
    rs_blocked = blocked(rs_idx);
    rt_blocked = blocked(rt_idx);
    rd_blocked = blocked(rd_idx);
  end

endmodule

// File: rtl/register_read_unit.sv
// Operand-read stage: 32x32 register file, RAW/WAW scoreboard stall and a
// one-entry valid/ready output stage toward execute.
// Widths/counts come from regfile_pkg (DATA_WIDTH, NUM_REGS, ADDR_WIDTH).
// Optional macro REGFILE_BYPASS_EN: same-cycle writeback forwarding into the
// read ports and into the hazard check. Without it reads see reg[] only.
module register_read_unit
  import regfile_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  register_read_unit_if.slave  bus
);

  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs;

  logic      wb_hit;
  logic      stage_free;
  logic      accept;
  logic      issue_ready;
  logic      rs_blk, rt_blk, rd_blk;
  reg_data_t rs_val, rt_val;

  logic      out_valid;
  reg_data_t rs_q, rt_q;
  reg_idx_t  rd_q;
  logic      wen_q;

  assign wb_hit      = bus.wb_valid && (bus.wb_rd != REG_ZERO);
  assign stage_free  = !out_valid || bus.out_ready;
  assign issue_ready = stage_free && !rs_blk && !rt_blk && !(bus.issue_wen && rd_blk);
  assign accept      = bus.issue_valid && issue_ready;

  reg_scoreboard u_sb (
    .clk        (clk),
    .rst_n      (rst_n),
    .set_en     (accept && bus.issue_wen && (bus.issue_rd != REG_ZERO)),
    .set_idx    (bus.issue_rd),
    .clr_en     (wb_hit),
    .clr_idx    (bus.wb_rd),
    .rs_idx     (bus.issue_rs),
    .rt_idx     (bus.issue_rt),
    .rd_idx     (bus.issue_rd),
    .rs_blocked (rs_blk),
    .rt_blocked (rt_blk),
    .rd_blocked (rd_blk)
  );

  // register file write; r0 is never written and stays zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      regs <= '0;
    else if (wb_hit)
      regs[bus.wb_rd] <= bus.wb_data;
  end

  // read ports: r0 forced to zero, optional forwarding of the current writeback
  always_comb begin
    rs_val = regs[bus.issue_rs];
    rt_val = regs[bus.issue_rt];
`ifdef REGFILE_BYPASS_EN
    if (bus.wb_valid && bus.wb_rd == bus.issue_rs) rs_val = bus.wb_data;
    if (bus.wb_valid && bus.wb_rd == bus.issue_rt) rt_val = bus.wb_data;
`endif
    if (bus.issue_rs == REG_ZERO) rs_val = '0;
    if (bus.issue_rt == REG_ZERO) rt_val = '0;
  end

  // output stage: load on accept, drop valid on consume, otherwise hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      rs_q      <= '0;
      rt_q      <= '0;
      rd_q      <= '0;
      wen_q     <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      rs_q      <= rs_val;
      rt_q      <= rt_val;
      rd_q      <= bus.issue_rd;
      wen_q     <= bus.issue_wen;
    end else if (bus.out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign bus.issue_ready = issue_ready;
  assign bus.out_valid   = out_valid;
  assign bus.rs_data     = rs_q;
  assign bus.rt_data     = rt_q;
  assign bus.out_rd      = rd_q;
  assign bus.out_wen     = wen_q;

endmodule

// File: tb/tb_register_read_unit.sv
// Bench for register_read_unit: table of read vectors plus hand-written
// hazard, backpressure and reset sequences; operands checked via a queue
// filled on accept and drained on consume.
module tb_register_read_unit;
  import regfile_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  register_read_unit_if bus();

  register_read_unit dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    reg_data_t d_rs;
    reg_data_t d_rt;
    reg_idx_t  rd;
    logic      wen;
  } exp_t;

  typedef struct {
    reg_idx_t  rs, rt, rd;
    logic      wen;
    reg_data_t d_rs, d_rt;
  } vec_t;

  int   checks = 0;
  int   passed = 0;
  exp_t sb[$];
  exp_t nxt;
  vec_t vecs[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %b want %b", nm, act, exp);
  endtask

  function automatic vec_t mk(reg_idx_t rs, reg_idx_t rt, reg_idx_t rd, logic wen,
                              reg_data_t a, reg_data_t b);
    vec_t v;
    v.rs = rs; v.rt = rt; v.rd = rd; v.wen = wen; v.d_rs = a; v.d_rt = b;
    return v;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_issue(input logic v, input reg_idx_t rs, input reg_idx_t rt,
                           input reg_idx_t rd, input logic wen,
                           input reg_data_t a, input reg_data_t b);
    bus.issue_valid = v;
    bus.issue_rs    = rs;
    bus.issue_rt    = rt;
    bus.issue_rd    = rd;
    bus.issue_wen   = wen;
    nxt.d_rs = a; nxt.d_rt = b; nxt.rd = rd; nxt.wen = wen;
  endtask

  task automatic wb(input logic v, input reg_idx_t rd, input reg_data_t d);
    bus.wb_valid = v;
    bus.wb_rd    = rd;
    bus.wb_data  = d;
  endtask

  // drive a writeback that releases a stalled, already-offered issue
  task automatic wb_release(input string nm, input reg_idx_t rd, input reg_data_t d);
    wb(1'b1, rd, d);
`ifdef REGFILE_BYPASS_EN
    @(negedge clk); chk1({nm, "_same_cycle"}, bus.issue_ready, 1'b1);
    tick;
    wb(1'b0, '0, '0);
`else
    @(negedge clk); chk1({nm, "_wb_cycle"}, bus.issue_ready, 1'b0);
    tick;
    wb(1'b0, '0, '0);
    @(negedge clk); chk1({nm, "_next_cycle"}, bus.issue_ready, 1'b1);
    tick;
`endif
    set_issue(1'b0, '0, '0, '0, 1'b0, '0, '0);
    @(negedge clk); chk1({nm, "_out_valid"}, bus.out_valid, 1'b1);
    tick;
  endtask

  // scoreboard: drain on consume first, then record a new accept
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("sb_rs_data", bus.rs_data, e.d_rs);
          chk("sb_rt_data", bus.rt_data, e.d_rt);
          chk("sb_out_rd", 32'(bus.out_rd), 32'(e.rd));
          chk1("sb_out_wen", bus.out_wen, e.wen);
        end
      end
      if (bus.issue_valid && bus.issue_ready) sb.push_back(nxt);
    end
  end

  always @(negedge rst_n) sb.delete();

  reg_idx_t  pidx[6] = '{5'd1, 5'd2, 5'd3, 5'd5, 5'd6, 5'd10};
  reg_data_t pval[6] = '{32'h11111111, 32'h22222222, 32'hAAAAAAAA,
                         32'h55555555, 32'hDEADBEEF, 32'h0F0F0F0F};

  initial begin
    vecs[0] = mk(5'd3,  5'd0,  5'd12, 1'b0, 32'hAAAAAAAA, 32'h00000000);
    vecs[1] = mk(5'd1,  5'd2,  5'd13, 1'b0, 32'h11111111, 32'h22222222);
    vecs[2] = mk(5'd6,  5'd10, 5'd0,  1'b0, 32'hDEADBEEF, 32'h0F0F0F0F);
    vecs[3] = mk(5'd5,  5'd5,  5'd31, 1'b0, 32'h55555555, 32'h55555555);
    vecs[4] = mk(5'd31, 5'd4,  5'd1,  1'b0, 32'h00000000, 32'h00000000);
    vecs[5] = mk(5'd0,  5'd6,  5'd0,  1'b1, 32'h00000000, 32'hDEADBEEF);

    set_issue(1'b0, '0, '0, '0, 1'b0, '0, '0);
    wb(1'b0, '0, '0);
    bus.out_ready = 1'b1;

    // reset state
    repeat (3) @(negedge clk);
    chk1("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_rs_data", bus.rs_data, 32'h0);
    chk("rst_rt_data", bus.rt_data, 32'h0);
    chk("rst_out_rd", 32'(bus.out_rd), 32'h0);
    chk1("rst_out_wen", bus.out_wen, 1'b0);
    chk1("rst_issue_ready", bus.issue_ready, 1'b1);
    tick;
    rst_n = 1'b1;
    tick;

    // r0 reads zero; one-cycle latency
    set_issue(1'b1, 5'd0, 5'd5, 5'd0, 1'b0, 32'h0, 32'h0);
    @(negedge clk); chk1("r0_ready", bus.issue_ready, 1'b1);
    tick;
    set_issue(1'b0, '0, '0, '0, 1'b0, '0, '0);
    @(negedge clk); chk1("r0_latency", bus.out_valid, 1'b1);
    tick;
    wb(1'b1, 5'd0, 32'hFFFFFFFF);
    tick;
    wb(1'b0, '0, '0);
    set_issue(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 32'h0, 32'h0);
    tick;
    set_issue(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0, 32'h0);
    @(negedge clk); chk1("r0_no_hazard", bus.issue_ready, 1'b1);
    tick;
    set_issue(1'b0, '0, '0, '0, 1'b0, '0, '0);

    // preload, then back-to-back read vectors at full rate
    for (int i = 0; i < 6; i++) begin
      wb(1'b1, pidx[i], pval[i]);
      tick;
    end
    wb(1'b0, '0, '0);
    for (int i = 0; i < 6; i++) begin
      set_issue(1'b1, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].wen,
                vecs[i].d_rs, vecs[i].d_rt);
      @(negedge clk); chk1("vec_ready", bus.issue_ready, 1'b1);
      tick;
    end
    set_issue(1'b0, '0, '0, '0, 1'b0, '0, '0);
    tick;

    // RAW stall on r7
    set_issue(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 32'h0, 32'h0);
    tick;
    set_issue(1'b1, 5'd7, 5'd0, 5'd8, 1'b0, 32'h12345678, 32'h0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); chk1("raw_stall", bus.issue_ready, 1'b0);
      tick;
    end
    wb_release("raw", 5'd7, 32'h12345678);

    // backpressure: hold stable 4 cycles, then release with no bubble
    bus.out_ready = 1'b0;
    set_issue(1'b1, 5'd1, 5'd2, 5'd20, 1'b0, 32'h11111111, 32'h22222222);
    tick;
    set_issue(1'b1, 5'd3, 5'd5, 5'd21, 1'b0, 32'hAAAAAAAA, 32'h55555555);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk1("bp_ready", bus.issue_ready, 1'b0);
      chk1("bp_valid", bus.out_valid, 1'b1);
      chk("bp_rs_hold", bus.rs_data, 32'h11111111);
      chk("bp_rt_hold", bus.rt_data, 32'h22222222);
      chk("bp_rd_hold", 32'(bus.out_rd), 32'd20);
      tick;
    end
    bus.out_ready = 1'b1;
    @(negedge clk); chk1("bp_release_ready", bus.issue_ready, 1'b1);
    tick;
    set_issue(1'b0, '0, '0, '0, 1'b0, '0, '0);
    @(negedge clk);
    chk1("bp_no_bubble", bus.out_valid, 1'b1);
    chk("bp_new_rd", 32'(bus.out_rd), 32'd21);
    tick;

    // WAW / set wins over a same-edge clear of r9
`ifdef REGFILE_BYPASS_EN
    set_issue(1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 32'h0, 32'h0);
    tick;
`endif
    set_issue(1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 32'h0, 32'h0);
    wb(1'b1, 5'd9, 32'h900D0009);
    @(negedge clk); chk1("waw_accept", bus.issue_ready, 1'b1);
    tick;
    wb(1'b0, '0, '0);
    set_issue(1'b1, 5'd9, 5'd0, 5'd0, 1'b0, 32'h99990009, 32'h0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); chk1("waw_set_wins", bus.issue_ready, 1'b0);
      tick;
    end
    wb_release("waw", 5'd9, 32'h99990009);

    // async reset mid-operation
    bus.out_ready = 1'b0;
    set_issue(1'b1, 5'd0, 5'd0, 5'd4, 1'b1, 32'h0, 32'h0);
    tick;
    set_issue(1'b0, '0, '0, '0, 1'b0, '0, '0);
    @(negedge clk); chk1("mid_pre_valid", bus.out_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk1("mid_out_valid", bus.out_valid, 1'b0);
    chk("mid_out_rd", 32'(bus.out_rd), 32'd0);
    chk1("mid_out_wen", bus.out_wen, 1'b0);
    #1 rst_n = 1'b1;
    tick;
    bus.out_ready = 1'b1;
    set_issue(1'b1, 5'd4, 5'd1, 5'd0, 1'b0, 32'h0, 32'h0);
    @(negedge clk); chk1("mid_no_stall", bus.issue_ready, 1'b1);
    tick;
    set_issue(1'b0, '0, '0, '0, 1'b0, '0, '0);
    @(negedge clk); chk1("mid_out_valid_after", bus.out_valid, 1'b1);
    tick;
    tick;

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
